// File: rtl/div_unit_pkg.sv
// Shared definitions for the iterative divider: default operand width,
// sequencer state encodings and the handshake level constants.
package div_unit_pkg;

  // Default operand width; the double width is derived from it where used.
  localparam int DivDataWidthDef = 32;

  // Sequencer state encodings.
  localparam logic [1:0] DivFree   = 2'b00;
  localparam logic [1:0] DivByZero = 2'b01;
  localparam logic [1:0] DivOn     = 2'b10;
  localparam logic [1:0] DivEnd    = 2'b11;

  // Handshake levels.
  localparam logic DivResultReady    = 1'b1;
  localparam logic DivResultNotReady = 1'b0;
  localparam logic DivStart          = 1'b1;
  localparam logic DivStop           = 1'b0;

endpackage : div_unit_pkg

// File: rtl/div_unit.sv
// Multi-cycle restoring divider for the EX stage.
// One shift-subtract iteration per cycle; the result is presented as
// {remainder, quotient} and held while the EX stage keeps start_i high.
// The EX stage keeps its stall request asserted while start_i=1 and ready_o=0.
// Optional feature macro: DIV_SIGNED_EN (signed DIV support; without it every
// divide is unsigned and signed_div_i is ignored).
module div_unit
  import div_unit_pkg::*;
#(
  parameter int DATA_W = DivDataWidthDef
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_i,
  input  logic                  annul_i,
  input  logic                  signed_div_i,
  input  logic [DATA_W-1:0]     opdata1_i,
  input  logic [DATA_W-1:0]     opdata2_i,
  output logic [2*DATA_W-1:0]   result_o,
  output logic                  ready_o
);

  localparam int DoubleDataWidth = 2 * DATA_W;
  localparam int CntW            = $clog2(DATA_W) + 1;

  localparam logic [CntW-1:0]          ZeroCnt  = {CntW{1'b0}};
  localparam logic [CntW-1:0]          OneCnt   = {{(CntW-1){1'b0}}, 1'b1};
  localparam logic [CntW-1:0]          LastCnt  = CntW'(DATA_W - 1);
  localparam logic [DATA_W-1:0]        ZeroW    = {DATA_W{1'b0}};
  localparam logic [DoubleDataWidth-1:0] ZeroD  = {DoubleDataWidth{1'b0}};
  localparam logic [DoubleDataWidth:0] ZeroWork = {(DoubleDataWidth+1){1'b0}};

  // Sequencer and datapath state.
  logic [1:0]                 state_r;
  logic [CntW-1:0]            cnt_r;
  logic [DoubleDataWidth:0]   work_r;
  logic [DATA_W-1:0]          divisor_r;

  // Next-state values.
  logic [1:0]                 state_nxt_s;
  logic [CntW-1:0]            cnt_nxt_s;
  logic [DoubleDataWidth:0]   work_nxt_s;
  logic [DATA_W-1:0]          divisor_nxt_s;
  logic [DoubleDataWidth-1:0] result_nxt_s;
  logic                       ready_nxt_s;

  // Datapath intermediates.
  logic                       accept_s;
  logic [DATA_W-1:0]          op1_abs_s;
  logic [DATA_W-1:0]          op2_abs_s;
  logic [DATA_W:0]            trial_s;
  logic [DoubleDataWidth:0]   step_s;
  logic [DATA_W-1:0]          quot_raw_s;
  logic [DATA_W-1:0]          rem_raw_s;
  logic [DATA_W-1:0]          quot_fix_s;
  logic [DATA_W-1:0]          rem_fix_s;

`ifdef DIV_SIGNED_EN
  localparam logic [DATA_W-1:0] OneW = {{(DATA_W-1){1'b0}}, 1'b1};

  // Sign corrections captured at accept time, applied when the result is presented.
  logic neg_quot_r;
  logic neg_rem_r;
  logic op1_neg_s;
  logic op2_neg_s;

  // Magnitudes of the operands for a signed divide; most-negative maps to its own bit pattern.
  always_comb begin
    op1_neg_s = signed_div_i & opdata1_i[DATA_W-1];
    op2_neg_s = signed_div_i & opdata2_i[DATA_W-1];
    if (op1_neg_s) begin
      op1_abs_s = ~opdata1_i + OneW;
    end else begin
      op1_abs_s = opdata1_i;
    end
    if (op2_neg_s) begin
      op2_abs_s = ~opdata2_i + OneW;
    end else begin
      op2_abs_s = opdata2_i;
    end
  end

  // Quotient negated on differing signs, remainder follows the dividend sign.
  always_comb begin
    if (neg_quot_r) begin
      quot_fix_s = ~quot_raw_s + OneW;
    end else begin
      quot_fix_s = quot_raw_s;
    end
    if (neg_rem_r) begin
      rem_fix_s = ~rem_raw_s + OneW;
    end else begin
      rem_fix_s = rem_raw_s;
    end
  end

  // Latch the sign corrections for the operation being accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      neg_quot_r <= 1'b0;
      neg_rem_r  <= 1'b0;
    end else if (accept_s) begin
      neg_quot_r <= op1_neg_s ^ op2_neg_s;
      neg_rem_r  <= op1_neg_s;
    end else begin
      neg_quot_r <= neg_quot_r;
      neg_rem_r  <= neg_rem_r;
    end
  end
`else
  // signed_div_i has no effect in the unsigned-only build.
  logic unused_signed_div_s;

  // Unsigned-only build: operands and results pass straight through.
  always_comb begin
    unused_signed_div_s = signed_div_i;
    op1_abs_s           = opdata1_i;
    op2_abs_s           = opdata2_i;
    quot_fix_s          = quot_raw_s;
    rem_fix_s           = rem_raw_s;
  end
`endif

  // Accept a new non-zero-divisor request only from FREE and only when not flushed.
  always_comb begin
    if ((state_r == DivFree) && (start_i == DivStart) && !annul_i && (opdata2_i != ZeroW)) begin
      accept_s = 1'b1;
    end else begin
      accept_s = 1'b0;
    end
  end

  // One restoring iteration: trial-subtract the divisor from the upper window.
  always_comb begin
    trial_s    = {1'b0, work_r[DoubleDataWidth-1:DATA_W]} - {1'b0, divisor_r};
    quot_raw_s = work_r[DATA_W-1:0];
    rem_raw_s  = work_r[DoubleDataWidth:DATA_W+1];
    if (trial_s[DATA_W]) begin
      step_s = {work_r[DoubleDataWidth-1:0], 1'b0};
    end else begin
      step_s = {trial_s[DATA_W-1:0], work_r[DATA_W-1:0], 1'b1};
    end
  end

  // Sequencer: next state, working register updates and the values the outputs will register.
  always_comb begin
    state_nxt_s   = state_r;
    cnt_nxt_s     = cnt_r;
    work_nxt_s    = work_r;
    divisor_nxt_s = divisor_r;
    result_nxt_s  = result_o;
    ready_nxt_s   = ready_o;
    case (state_r)
      DivFree: begin
        result_nxt_s = ZeroD;
        ready_nxt_s  = DivResultNotReady;
        if ((start_i == DivStart) && !annul_i) begin
          if (opdata2_i == ZeroW) begin
            state_nxt_s = DivByZero;
          end else begin
            state_nxt_s   = DivOn;
            cnt_nxt_s     = ZeroCnt;
            work_nxt_s    = {ZeroW, op1_abs_s, 1'b0};
            divisor_nxt_s = op2_abs_s;
          end
        end else begin
          state_nxt_s = DivFree;
        end
      end
      DivByZero: begin
        if (annul_i) begin
          state_nxt_s  = DivFree;
          result_nxt_s = ZeroD;
          ready_nxt_s  = DivResultNotReady;
        end else begin
          state_nxt_s = DivEnd;
          work_nxt_s  = ZeroWork;
        end
      end
      DivOn: begin
        if (annul_i) begin
          state_nxt_s  = DivFree;
          cnt_nxt_s    = ZeroCnt;
          result_nxt_s = ZeroD;
          ready_nxt_s  = DivResultNotReady;
        end else begin
          work_nxt_s = step_s;
          cnt_nxt_s  = cnt_r + OneCnt;
          if (cnt_r == LastCnt) begin
            state_nxt_s = DivEnd;
          end else begin
            state_nxt_s = DivOn;
          end
        end
      end
      DivEnd: begin
        cnt_nxt_s = ZeroCnt;
        if (start_i == DivStop) begin
          state_nxt_s  = DivFree;
          result_nxt_s = ZeroD;
          ready_nxt_s  = DivResultNotReady;
        end else begin
          state_nxt_s  = DivEnd;
          result_nxt_s = {rem_fix_s, quot_fix_s};
          ready_nxt_s  = DivResultReady;
        end
      end
      default: begin
        state_nxt_s  = DivFree;
        cnt_nxt_s    = ZeroCnt;
        result_nxt_s = ZeroD;
        ready_nxt_s  = DivResultNotReady;
      end
    endcase
  end

  // State, working register and registered outputs; reset forces FREE with cleared outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= DivFree;
      cnt_r     <= ZeroCnt;
      work_r    <= ZeroWork;
      divisor_r <= ZeroW;
      result_o  <= ZeroD;
      ready_o   <= DivResultNotReady;
    end else begin
      state_r   <= state_nxt_s;
      cnt_r     <= cnt_nxt_s;
      work_r    <= work_nxt_s;
      divisor_r <= divisor_nxt_s;
      result_o  <= result_nxt_s;
      ready_o   <= ready_nxt_s;
    end
  end

endmodule : div_unit

// File: doc/div_unit.md
DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, with ports named clk and rst_n.
REQ-002 Parameter DATA_W SHALL default to 32 and set the operand width.
REQ-003 Port clk SHALL be an input, 1 bit wide, and is the rising-edge clock.
REQ-004 Port rst_n SHALL be an input, 1 bit wide, and is the asynchronous active-low reset.
REQ-005 Port start_i SHALL be an input, 1 bit wide, and is a level request from the EX stage to divide.
REQ-006 Port annul_i SHALL be an input, 1 bit wide, and cancels an operation in progress (pipeline flush).
REQ-007 Port signed_div_i SHALL be an input, 1 bit wide, and is 1 for DIV and 0 for DIVU.
REQ-008 Port opdata1_i SHALL be an input, DATA_W bits wide, and is the dividend.
REQ-009 Port opdata2_i SHALL be an input, DATA_W bits wide, and is the divisor.
REQ-010 Port result_o SHALL be an output, 2*DATA_W bits wide, holding {remainder, quotient}: the high half goes to HI and the low half to LO.
REQ-011 Port ready_o SHALL be an output, 1 bit wide, and is high while result_o is valid.

Function
REQ-012 The FSM SHALL have four states: FREE, BYZERO, ON, END.
REQ-013 In FREE with start_i=1 and annul_i=0: if the divisor is 0 the next state SHALL be BYZERO; otherwise the next state SHALL be ON, the operands SHALL be latched, and the iteration counter SHALL be cleared.
REQ-014 In FREE with start_i=0, ready_o and result_o SHALL be 0.
REQ-015 BYZERO SHALL go to END after one cycle, with a forced result of 0.
REQ-016 ON SHALL perform one restoring shift-subtract iteration per cycle, DATA_W iterations total, and then go to END.
REQ-017 Latency: the start edge is E0, iterations occur on edges E1..E32, and ready_o=1 with a valid result_o SHALL be registered at E33 (DATA_W=32).
REQ-018 Divide-by-zero: ready_o=1 with result_o=0 SHALL be registered at E2.
REQ-019 In END, ready_o and result_o SHALL hold while start_i=1.
REQ-020 In END with start_i=0, the next state SHALL be FREE and ready_o and result_o SHALL clear to 0 on that edge.
REQ-021 annul_i=1 in ON or BYZERO SHALL force FREE on the next edge, with ready_o=0 and no result produced.
REQ-022 annul_i=1 sampled in FREE SHALL block acceptance of start_i.
REQ-023 Operand changes after the accept edge SHALL be ignored until the next FREE.
REQ-024 Signed divide: the operation SHALL use the absolute values of both operands. The quotient SHALL be negated when the operand signs differ, and the remainder SHALL take the sign of the dividend.
REQ-025 Signed overflow (most-negative dividend / -1) SHALL wrap, giving quotient 0x80000000 and remainder 0, with no trap.
REQ-026 The internal working register SHALL be 2*DATA_W+1 bits, and the counter SHALL be clog2(DATA_W)+1 bits.

Reset
REQ-027 When rst_n=0, the block SHALL asynchronously force state FREE, counter 0, result_o=0, and ready_o=0, including during ON or END.
REQ-028 After release of reset, the first start_i accept SHALL occur no earlier than the first rising edge.

Configuration
REQ-029 The macro DIV_SIGNED_EN SHALL control signed division.
REQ-030 With DIV_SIGNED_EN defined, signed_div_i SHALL be honoured as described in REQ-024 and REQ-025.
REQ-031 Without DIV_SIGNED_EN, signed_div_i SHALL be ignored, all divides SHALL be unsigned, and the sign/negation logic SHALL be absent.

Structure
REQ-032 The shared definitions file SHALL hold the state encodings (DivFree, DivByZero, DivOn, DivEnd) and the DivResultReady/DivResultNotReady and DivStart/DivStop constants.
REQ-033 DATA_W and DoubleDataWidth SHALL come from the existing width defines.
REQ-034 The design SHALL be a single module with no sub-module, and the absolute-value and negation logic SHALL be inline.
REQ-035 The EX stage SHALL consume ready_o and result_o and hold the stall request to ctrl while start_i=1 and ready_o=0.

Verification
REQ-036 Scenario, unsigned 100/7: start_i=1 at E0 -> ready_o=1 at E33 with result_o={0x00000002, 0x0000000E}.
REQ-037 Scenario, signed -7/2 (0xFFFFFFF9/0x00000002): -> result_o={0xFFFFFFFF, 0xFFFFFFFD} at E33.
REQ-038 Scenario, divide by zero 5/0: -> ready_o=1 at E2, result_o=0; deasserting start_i returns to FREE and ready_o=0 on the next edge.
REQ-039 Scenario, annul: annul_i=1 for one cycle at E10 -> ready_o stays 0 through E40; a fresh 9/3 start then yields {0, 3} 33 cycles later.
REQ-040 Scenario, reset mid-operation: rst_n pulsed low at E15, asynchronous to clk -> outputs are 0 immediately, state is FREE, and a new 1/1 divide yields {0, 1} at E33.
REQ-041 Scenario, signed overflow: 0x80000000/0xFFFFFFFF signed -> {0x00000000, 0x80000000}; without DIV_SIGNED_EN the same operands give {0x80000000, 0x00000000}.
